// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution stream blocks.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} tx_state_t;

  // Number of valid-overlap outputs produced per frame.
  function automatic int n_out(input int x_size, input int f_size);
    return x_size - f_size + 1;
  endfunction

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; rdata always shows the head entry.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [AW:0]                      wr_ptr, rd_ptr;
  logic                             do_push, do_pop;

  // Extra pointer MSB separates full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/conv_y_out_tx.sv
// Output side of the convolution stream: buffers y results and sends one
// frame of N_OUT beats downstream, marking the last beat and signalling drain.
module conv_y_out_tx
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int X_SIZE     = 128,
  parameter int F_SIZE     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  conv_start,
  input  logic                  y_valid,
  input  logic [DATA_WIDTH-1:0] y_data,
  output logic                  y_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  overflow_err
);

  localparam int N_OUT = n_out(X_SIZE, F_SIZE);
  localparam int CW    = cnt_w(N_OUT);

  localparam logic [CW-1:0] CNT_END  = CW'(N_OUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_OUT - 1);

  tx_state_t     state, state_nxt;
  logic [CW-1:0] in_cnt, out_cnt;
  logic          fifo_full, fifo_empty;
  logic          push, pop, arm;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (y_data),
    .pop     (pop),
    .rdata   (m_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // y_ready uses registered state only, so a full FIFO blocks a push even
  // when a pop frees a slot in the same cycle.
  assign y_ready    = (state == ACTIVE) && !fifo_full && (in_cnt < CNT_END);
  assign push       = y_valid && y_ready;
  assign m_valid    = !fifo_empty;
  assign pop        = m_valid && m_ready;
  assign m_last     = m_valid && (out_cnt == CNT_LAST);
  assign busy       = (state == ACTIVE) || (state == DRAIN);
  assign frame_done = (state == DONE);
  assign arm        = (state == IDLE) && conv_start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (conv_start) state_nxt = ACTIVE;
      ACTIVE:  if (push && (in_cnt == CNT_LAST)) state_nxt = DRAIN;
      DRAIN:   if (pop && m_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_cnt       <= '0;
      out_cnt      <= '0;
      overflow_err <= 1'b0;
    end else if (arm) begin
      in_cnt       <= '0;
      out_cnt      <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) in_cnt <= in_cnt + CW'(1);
      if (pop && busy) out_cnt <= out_cnt + CW'(1);
      if (y_valid && !y_ready) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_y_out_tx.sv
// Directed bench for conv_y_out_tx at default parameters (97-beat frames).
module tb_conv_y_out_tx;

  logic        clk, reset_n;
  logic        conv_start, y_valid, y_ready;
  logic [15:0] y_data, m_data;
  logic        m_valid, m_ready, m_last, frame_done, busy, overflow_err;

  int n_cmp = 0;
  int n_err = 0;
  int next_in, next_out;

  conv_y_out_tx dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .conv_start   (conv_start),
    .y_valid      (y_valid),
    .y_data       (y_data),
    .y_ready      (y_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .frame_done   (frame_done),
    .busy         (busy),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    conv_start = 1'b1;
    tick();
    conv_start = 1'b0;
  endtask

  // Feeds values next_in..96 with m_ready=1 and checks every popped beat
  // against next_out until frame_done. 'extra' keeps y_valid high past the
  // frame with a marker value that must never come out.
  task automatic stream(input string tag, input bit extra, input int start_at);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      conv_start = (c == start_at);
      m_ready    = 1'b1;
      y_valid    = (next_in < 97) || extra;
      y_data     = (next_in < 97) ? 16'(next_in) : 16'hBEEF;
      #1;
      if (y_valid && y_ready) next_in++;
      if (m_valid) begin
        chk({tag, " data"}, 32'(m_data), 32'(next_out));
        chk({tag, " last"}, 32'(m_last), 32'(next_out == 96));
        next_out++;
      end
      @(posedge clk);
      #1;
      if (frame_done) done = 1'b1;
    end
    conv_start = 1'b0;
    y_valid    = 1'b0;
    chk({tag, " frame_done seen"}, 32'(done), 32'd1);
    chk({tag, " beats out"}, 32'(next_out), 32'd97);
  endtask

  initial begin
    reset_n    = 1'b0;
    conv_start = 1'b0;
    y_valid    = 1'b0;
    y_data     = '0;
    m_ready    = 1'b0;
    #2;
    chk("rst y_ready", 32'(y_ready), 0);
    chk("rst m_valid", 32'(m_valid), 0);
    chk("rst m_last", 32'(m_last), 0);
    chk("rst frame_done", 32'(frame_done), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst overflow", 32'(overflow_err), 0);
    chk("rst m_data", 32'(m_data), 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Plain streaming with one-cycle latency
    start();
    chk("stream busy", 32'(busy), 1);
    chk("stream y_ready", 32'(y_ready), 1);
    chk("stream m_valid idle", 32'(m_valid), 0);
    m_ready = 1'b1;
    y_valid = 1'b1;
    y_data  = 16'd0;
    tick();
    chk("latency m_valid", 32'(m_valid), 1);
    chk("latency m_data", 32'(m_data), 0);
    chk("latency m_last", 32'(m_last), 0);
    next_in  = 1;
    next_out = 0;
    stream("stream", 1'b0, -1);
    chk("done m_valid", 32'(m_valid), 0);
    chk("done busy", 32'(busy), 0);
    tick();
    chk("done pulse width", 32'(frame_done), 0);
    chk("stream overflow", 32'(overflow_err), 0);

    // Dropped beat in IDLE sets the sticky flag
    y_valid = 1'b1;
    y_data  = 16'd55;
    #1;
    chk("idle ovf before", 32'(overflow_err), 0);
    tick();
    y_valid = 1'b0;
    chk("idle ovf set", 32'(overflow_err), 1);
    chk("idle beat dropped", 32'(m_valid), 0);
    tick();
    chk("idle ovf sticky", 32'(overflow_err), 1);

    // Back-pressure: only FIFO_DEPTH beats get in, head holds stable
    start();
    chk("start clears ovf", 32'(overflow_err), 0);
    m_ready = 1'b0;
    next_in = 0;
    for (int c = 0; c < 10; c++) begin
      y_valid = 1'b1;
      y_data  = 16'(next_in);
      #1;
      if (y_ready) next_in++;
      if (m_valid) chk("bp head hold", 32'(m_data), 0);
      tick();
    end
    chk("bp pushes", 32'(next_in), 4);
    chk("bp y_ready", 32'(y_ready), 0);
    chk("bp m_valid", 32'(m_valid), 1);
    chk("bp m_data", 32'(m_data), 0);
    chk("bp m_last", 32'(m_last), 0);
    chk("bp ovf full", 32'(overflow_err), 1);
    next_out = 0;
    stream("bp", 1'b0, -1);
    tick();

    // Full FIFO with a simultaneous pop: push waits one cycle
    start();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      y_valid = 1'b1;
      y_data  = 16'(i);
      tick();
    end
    y_valid = 1'b0;
    #1;
    chk("full y_ready", 32'(y_ready), 0);
    chk("full head", 32'(m_data), 0);
    m_ready = 1'b1;
    y_valid = 1'b1;
    y_data  = 16'd4;
    #1;
    chk("full+pop y_ready", 32'(y_ready), 0);
    tick();
    chk("full+pop head", 32'(m_data), 1);
    chk("after pop y_ready", 32'(y_ready), 1);
    next_in  = 4;
    next_out = 1;
    stream("fullpop", 1'b0, -1);
    tick();

    // Excess beats during DRAIN/DONE are dropped and flagged
    start();
    chk("drain ovf clear", 32'(overflow_err), 0);
    next_in  = 0;
    next_out = 0;
    stream("drain", 1'b1, -1);
    chk("drain ovf set", 32'(overflow_err), 1);
    chk("drain no extra", 32'(m_valid), 0);
    tick();
    chk("drain no extra idle", 32'(m_valid), 0);
    chk("drain ovf sticky", 32'(overflow_err), 1);
    start();
    chk("ovf cleared by start", 32'(overflow_err), 0);

    // Asynchronous reset mid-frame with data buffered
    m_ready = 1'b1;
    next_in = 0;
    next_out = 0;
    for (int c = 0; c < 41; c++) begin
      y_valid = 1'b1;
      y_data  = 16'(next_in);
      #1;
      if (y_ready) next_in++;
      if (m_valid) next_out++;
      tick();
    end
    m_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      y_data = 16'(next_in);
      #1;
      if (y_ready) next_in++;
      tick();
    end
    y_valid = 1'b0;
    chk("mid outputs", 32'(next_out), 40);
    chk("mid buffered", 32'(next_in - next_out), 3);
    chk("mid m_valid", 32'(m_valid), 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async m_valid", 32'(m_valid), 0);
    chk("async y_ready", 32'(y_ready), 0);
    chk("async busy", 32'(busy), 0);
    chk("async m_data", 32'(m_data), 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post reset idle", 32'(busy), 0);
    start();
    next_in  = 0;
    next_out = 0;
    stream("post_reset", 1'b0, -1);
    tick();

    // conv_start during ACTIVE is ignored
    start();
    next_in  = 0;
    next_out = 0;
    stream("restart_ign", 1'b0, 10);
    tick();
    chk("restart single done", 32'(frame_done), 0);
    chk("restart idle", 32'(busy), 0);
    tick();
    chk("restart no 2nd done", 32'(frame_done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_y_out_tx.md
Name: conv_y_out_tx

Overview:
Transmit side of the convolution output stream. Takes y[k] results from the MAC datapath, buffers them in a small FIFO, and transmits them to the downstream master over the m_valid/m_ready handshake. It counts one frame of X_SIZE-F_SIZE+1 outputs, flags the last beat, and pulses frame_done once the frame has fully drained. Back-pressure reaches the datapath through y_ready.

Parameters:
DATA_WIDTH, 16, width of y samples and m_data.
X_SIZE, 128, input vector length per frame.
F_SIZE, 32, filter length.
FIFO_DEPTH, 4, output buffer entries; power of two, >= 2.

Ports:
clk  input  1  single clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
conv_start  input  1  arms a new frame; honoured only in IDLE.
y_valid  input  1  datapath result valid.
y_data  input  DATA_WIDTH  datapath result.
y_ready  output  1  block accepts y_data this cycle.
m_data  output  DATA_WIDTH  transmitted sample (FIFO head).
m_valid  output  1  m_data valid.
m_ready  input  1  downstream accepts.
m_last  output  1  current beat is the last of the frame.
frame_done  output  1  one-cycle pulse after the last beat is accepted.
busy  output  1  high in ACTIVE and DRAIN.
overflow_err  output  1  sticky; a y_valid beat was dropped.

Behaviour:
- Reset, asserted asynchronously: state=IDLE; FIFO emptied; counters=0. All outputs are 0: y_ready, m_valid, m_last, frame_done, busy, overflow_err, and m_data. Reset mid-frame discards buffered data.
- N_OUT = X_SIZE-F_SIZE+1 (97 at defaults). in_cnt and out_cnt are each $clog2(N_OUT+1) bits wide.
- Push when y_valid && y_ready. Pop when m_valid && m_ready.
- y_ready = (state==ACTIVE) && !fifo_full && (in_cnt < N_OUT). It is a combinational function of registered state only.
- Full plus pop in the same cycle: no push is allowed; y_ready stays low. Push resumes the next cycle.
- m_valid = !fifo_empty. It is registered-path, with no combinational path from y_valid.
- Latency: when the FIFO is empty, a y beat accepted at cycle t gives m_valid=1 with that data at t+1.
- While m_valid && !m_ready: m_data and m_last are held stable, and m_valid does not drop.
- m_last = m_valid && (out_cnt == N_OUT-1).
- State machine:
  - IDLE: conv_start → ACTIVE; in_cnt and out_cnt are cleared.
  - ACTIVE: a push increments in_cnt. When a push takes in_cnt to N_OUT → DRAIN.
  - DRAIN: no pushes. A pop with m_last → DONE.
  - DONE: frame_done=1 for exactly this cycle → IDLE.
- A pop increments out_cnt in ACTIVE and DRAIN. A frame whose last pop happens while still in ACTIVE cannot occur, because in_cnt leads out_cnt.
- overflow_err is set when y_valid && !y_ready. This covers IDLE, DRAIN, DONE, a full FIFO, and excess beats; the beat is dropped. It is cleared only by reset or by conv_start accepted in IDLE.
- conv_start outside IDLE is ignored and has no effect on counters.
- busy = (state==ACTIVE || state==DRAIN).

Decomposition:
- Shared package conv_pkg holds:
  - typedef enum {IDLE, ACTIVE, DRAIN, DONE} tx_state_t;
  - constant function n_out(X_SIZE, F_SIZE);
  - the counter-width helper.
- Sub-module sync_fifo (DATA_WIDTH, DEPTH) provides full/empty, push/pop, and asynchronous active-low reset. It is reused by other stream blocks. conv_y_out_tx holds only the FSM, counters, and flag logic.

Test Plan:
- Streaming, defaults, m_ready=1: conv_start, then y_data=0..96 one per cycle → m_data=0..96 each one cycle after push; m_last only with data 96; frame_done one cycle after that pop; overflow_err=0.
- Back-pressure: m_ready=0 for 10 cycles with y_valid held high → exactly 4 pushes; y_ready=0 afterwards; m_data holds 0 stable. On m_ready=1, all 97 values arrive in order with none lost.
- Full plus simultaneous pop: FIFO at 4 entries, m_ready=1 with y_valid=1 → no push that cycle; push the next cycle; count stays consistent.
- Overflow: y_valid=1 in IDLE → overflow_err=1 from the next cycle and holds. A 98th beat in DRAIN is not transmitted. The flag clears on the next conv_start.
- Reset mid-frame: reset_n low after 40 outputs with 3 buffered → m_valid, y_ready, and busy drop to 0 asynchronously. After release, a new conv_start produces a clean 97-beat frame.
- conv_start pulsed during ACTIVE → ignored; the frame still ends at exactly 97 beats with a single frame_done.
